interconnect_sfft_to_n_data: RTL and testbench

//  Generalised successor of the FFT-output splitter: captures one NFFT-point frame from the

---
 rtl/interconnect_sfft_to_n_data_pkg.sv | 29 ++
 rtl/interconnect_sfft_to_n_data_channel_buffer.sv | 76 +++++++
 rtl/interconnect_sfft_to_n_data.sv | 125 ++++++++++++
 tb/tb_interconnect_sfft_to_n_data.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interconnect_sfft_to_n_data_pkg.sv
// Shared types and index helpers for the FFT-output channel demultiplexer.
package interconnect_sfft_to_n_data_pkg;

    // Debug-visible frame states; encodings are exported on the state port.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StDrain = 2'd2
    } state_e;

    // Channel that sample k of a frame belongs to.
    function automatic int unsigned map_ch(input int unsigned k, input int unsigned log2_ch,
                                           input int unsigned log2_depth, input bit interleave);
        if (interleave) begin
            return k & ((32'd1 << log2_ch) - 32'd1);
        end
        return k >> log2_depth;
    endfunction

    // Slot inside the channel buffer that sample k lands in.
    function automatic int unsigned map_slot(input int unsigned k, input int unsigned log2_ch,
                                             input int unsigned log2_depth, input bit interleave);
        if (interleave) begin
            return k >> log2_ch;
        end
        return k & ((32'd1 << log2_depth) - 32'd1);
    endfunction

endpackage

// File: rtl/interconnect_sfft_to_n_data_channel_buffer.sv
// One output channel: DEPTH-entry sample store plus its own ready-driven read side.
module interconnect_sfft_to_n_data_channel_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned LOG2_DEPTH = 2,
    parameter int unsigned W          = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [LOG2_DEPTH-1:0] wr_addr_i,
    input  logic [2*W-1:0]        wr_data_i,
    input  logic                  drain_i,
    input  logic                  clr_i,
    input  logic                  ready_i,
    output logic [W-1:0]          data_i_o,
    output logic [W-1:0]          data_q_o,
    output logic                  complete_o,
    output logic                  last_o,
    output logic                  done_o
);

    localparam logic [LOG2_DEPTH:0] DepthCnt = (LOG2_DEPTH + 1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0] LastPtr  = (LOG2_DEPTH + 1)'(DEPTH - 1);

    logic [2*W-1:0]      mem_q [DEPTH];
    logic [LOG2_DEPTH:0] rd_ptr_q, rd_ptr_d;
    logic [2*W-1:0]      data_q, data_d;
    logic                complete_q, complete_d;
    logic                last_q, last_d;

    // rd_ptr counts one past DEPTH-1 so "drained" is a plain equality.
    assign done_o     = (rd_ptr_q == DepthCnt);
    assign data_i_o   = data_q[2*W-1:W];
    assign data_q_o   = data_q[W-1:0];
    assign complete_o = complete_q;
    assign last_o     = last_q;

    // Sample store: plain RAM, contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read side: a ready seen this cycle presents the next slot on the following cycle.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        data_d     = data_q;
        complete_d = 1'b0;
        last_d     = 1'b0;
        if (clr_i) begin
            rd_ptr_d = '0;
        end else if (drain_i && ready_i && !done_o) begin
            complete_d = 1'b1;
            data_d     = mem_q[rd_ptr_q[LOG2_DEPTH-1:0]];
            last_d     = (rd_ptr_q == LastPtr);
            rd_ptr_d   = rd_ptr_q + 1'b1;
        end
    end

    // Read-side state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q   <= '0;
            data_q     <= '0;
            complete_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            data_q     <= data_d;
            complete_q <= complete_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: rtl/interconnect_sfft_to_n_data.sv
// Captures one NFFT-point FFT frame and splits it across NCH independently drained channels.
module interconnect_sfft_to_n_data
    import interconnect_sfft_to_n_data_pkg::*;
#(
    parameter int unsigned SIZE_BUFFER   = 3,
    parameter int unsigned DATA_FFT_SIZE = 16,
    parameter int unsigned LOG2_CH       = 1,
    parameter string       MODE          = "interleave"
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                fft_valid,
    input  logic [DATA_FFT_SIZE-1:0]            data_from_fft_i,
    input  logic [DATA_FFT_SIZE-1:0]            data_from_fft_q,
    output logic                                resiveFromSecond,
    input  logic [(1<<LOG2_CH)-1:0]             flag_ready_recive,
    output logic [(1<<LOG2_CH)*DATA_FFT_SIZE-1:0] data_fft_i,
    output logic [(1<<LOG2_CH)*DATA_FFT_SIZE-1:0] data_fft_q,
    output logic [(1<<LOG2_CH)-1:0]             complete,
    output logic [(1<<LOG2_CH)-1:0]             last,
    output logic                                overflow,
    output logic [1:0]                          state
);

    localparam int unsigned NFFT       = 1 << SIZE_BUFFER;
    localparam int unsigned NCH        = 1 << LOG2_CH;
    localparam int unsigned DEPTH      = NFFT / NCH;
    localparam int unsigned LOG2_DEPTH = SIZE_BUFFER - LOG2_CH;
    localparam int unsigned W          = DATA_FFT_SIZE;
    localparam bit          INTERLEAVE = (MODE == "interleave");
    localparam logic [SIZE_BUFFER-1:0] LastK = '1;

    state_e                 state_q, state_d;
    logic [SIZE_BUFFER-1:0] wr_cnt_q, wr_cnt_d;
    logic                   overflow_q, overflow_d;
    logic [NCH-1:0]         ch_done;
    logic                   all_done, drain, clr, wr_en;
    logic [31:0]            wr_ch;
    logic [LOG2_DEPTH-1:0]  wr_slot;

    assign drain            = (state_q == StDrain);
    assign all_done         = &ch_done;
    assign clr              = drain && all_done;
    // Samples are only accepted while the FFT is told we are ready.
    assign wr_en            = fft_valid && !drain;
    assign resiveFromSecond = !drain;
    assign overflow         = overflow_q;
    assign state            = state_q;

    assign wr_ch   = map_ch(32'(wr_cnt_q), LOG2_CH, LOG2_DEPTH, INTERLEAVE);
    assign wr_slot = LOG2_DEPTH'(map_slot(32'(wr_cnt_q), LOG2_CH, LOG2_DEPTH, INTERLEAVE));

    // Frame FSM: count samples in, wait for every channel to drain, overflow is sticky.
    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        overflow_d = overflow_q;
        unique case (state_q)
            StIdle: begin
                if (fft_valid) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    state_d  = StFill;
                end
            end
            StFill: begin
                if (fft_valid) begin
                    if (wr_cnt_q == LastK) begin
                        wr_cnt_d = '0;
                        state_d  = StDrain;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (fft_valid) begin
                    overflow_d = 1'b1;
                end
                if (all_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                wr_cnt_d = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        interconnect_sfft_to_n_data_channel_buffer #(
            .DEPTH      (DEPTH),
            .LOG2_DEPTH (LOG2_DEPTH),
            .W          (W)
        ) u_buf (
            .clk_i      (clk),
            .rst_ni     (reset),
            .wr_en_i    (wr_en && (wr_ch == 32'(c))),
            .wr_addr_i  (wr_slot),
            .wr_data_i  ({data_from_fft_i, data_from_fft_q}),
            .drain_i    (drain),
            .clr_i      (clr),
            .ready_i    (flag_ready_recive[c]),
            .data_i_o   (data_fft_i[c*W +: W]),
            .data_q_o   (data_fft_q[c*W +: W]),
            .complete_o (complete[c]),
            .last_o     (last[c]),
            .done_o     (ch_done[c])
        );
    end

endmodule

// File: tb/tb_interconnect_sfft_to_n_data.sv
// Scoreboard bench: dut0 = defaults (8 points, 2 ch, interleave), dut1 = 16 points, 4 ch, block.
module tb_interconnect_sfft_to_n_data;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic           fv0, fv1;
    logic [W-1:0]   di0, dq0, di1, dq1;
    logic [5:0]     ready_g;
    logic           rs0, rs1, ovf0, ovf1;
    logic [1:0]     st0, st1;
    logic [2*W-1:0] oi0, oq0;
    logic [4*W-1:0] oi1, oq1;
    logic [1:0]     cmp0, last0;
    logic [3:0]     cmp1, last1;

    interconnect_sfft_to_n_data u_dut0 (
        .clk               (clk),
        .reset             (reset),
        .fft_valid         (fv0),
        .data_from_fft_i   (di0),
        .data_from_fft_q   (dq0),
        .resiveFromSecond  (rs0),
        .flag_ready_recive (ready_g[1:0]),
        .data_fft_i        (oi0),
        .data_fft_q        (oq0),
        .complete          (cmp0),
        .last              (last0),
        .overflow          (ovf0),
        .state             (st0)
    );

    interconnect_sfft_to_n_data #(
        .SIZE_BUFFER   (4),
        .DATA_FFT_SIZE (16),
        .LOG2_CH       (2),
        .MODE          ("block")
    ) u_dut1 (
        .clk               (clk),
        .reset             (reset),
        .fft_valid         (fv1),
        .data_from_fft_i   (di1),
        .data_from_fft_q   (dq1),
        .resiveFromSecond  (rs1),
        .flag_ready_recive (ready_g[5:2]),
        .data_fft_i        (oi1),
        .data_fft_q        (oq1),
        .complete          (cmp1),
        .last              (last1),
        .overflow          (ovf1),
        .state             (st1)
    );

    // Reference model state. Global channel g: 0..1 -> dut0, 2..5 -> dut1.
    int         n_chk = 0;
    int         n_err = 0;
    logic [2*W:0] sbq [6][$];
    int         left [6];
    int         k [2];
    bit         drain_flag [2];
    bit         done_seen [2];
    logic       ovf_exp [2];
    logic [5:0] exp_next = '0;
    logic [5:0] exp_cmp = '0;
    bit         mon_en = 1'b0;

    function automatic int nfft_of(input int d); return (d == 0) ? 8 : 16; endfunction
    function automatic int nch_of(input int d);  return (d == 0) ? 2 : 4;  endfunction
    function automatic int base_of(input int d); return (d == 0) ? 0 : 2;  endfunction
    function automatic int dut_of(input int g);  return (g < 2) ? 0 : 1;   endfunction

    function automatic logic [1:0] exp_st(input int d);
        if (drain_flag[d]) return 2'd2;
        return (k[d] != 0) ? 2'd1 : 2'd0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Sample k goes to channel k mod NCH (interleave) or k / DEPTH (block).
    task automatic push_sample(input int d, input logic [W-1:0] i, input logic [W-1:0] q);
        int depth, ch, slot;
        depth = nfft_of(d) / nch_of(d);
        ch    = (d == 0) ? k[d] % nch_of(d) : k[d] / depth;
        slot  = (d == 0) ? k[d] / nch_of(d) : k[d] % depth;
        sbq[base_of(d) + ch].push_back({i, q, slot == depth - 1});
    endtask

    // One clock of stimulus; called #1 after a rising edge, returns #1 after the next one.
    task automatic step(input logic v0, input logic v1, input logic [5:0] rdy, input bit seq);
        bit acc [2];
        bit ov [2];
        bit all_zero;
        fv0 = v0;
        fv1 = v1;
        ready_g = rdy;
        di0 = seq ? W'(k[0]) : W'($urandom);
        dq0 = W'($urandom);
        di1 = seq ? W'(k[1]) : W'($urandom);
        dq1 = W'($urandom);
        acc[0] = v0 && !drain_flag[0];
        ov[0]  = v0 && drain_flag[0];
        acc[1] = v1 && !drain_flag[1];
        ov[1]  = v1 && drain_flag[1];
        if (acc[0]) push_sample(0, di0, dq0);
        if (acc[1]) push_sample(1, di1, dq1);
        for (int g = 0; g < 6; g++) begin
            exp_next[g] = drain_flag[dut_of(g)] && rdy[g] && (left[g] > 0);
            if (exp_next[g]) left[g]--;
        end
        @(posedge clk);
        #1;
        exp_next = '0;
        for (int d = 0; d < 2; d++) begin
            if (ov[d]) ovf_exp[d] = 1'b1;
            all_zero = 1'b1;
            for (int c = 0; c < nch_of(d); c++) begin
                if (left[base_of(d) + c] != 0) all_zero = 1'b0;
            end
            if (done_seen[d]) begin
                drain_flag[d] = 1'b0;
                done_seen[d]  = 1'b0;
            end else if (drain_flag[d] && all_zero) begin
                done_seen[d] = 1'b1;
            end
            if (acc[d]) begin
                k[d]++;
                if (k[d] == nfft_of(d)) begin
                    k[d] = 0;
                    drain_flag[d] = 1'b1;
                    for (int c = 0; c < nch_of(d); c++) begin
                        left[base_of(d) + c] = nfft_of(d) / nch_of(d);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset = 1'b0;
        fv0 = 1'b0;
        fv1 = 1'b0;
        ready_g = '0;
        #2;
        chk("rst_ready0", 64'(rs0), 64'(1));
        chk("rst_ready1", 64'(rs1), 64'(1));
        chk("rst_state0", 64'(st0), 64'(0));
        chk("rst_state1", 64'(st1), 64'(0));
        chk("rst_complete", 64'({cmp1, cmp0}), 64'(0));
        chk("rst_last", 64'({last1, last0}), 64'(0));
        chk("rst_data0", 64'({oi0, oq0}), 64'(0));
        chk("rst_data1_i", oi1, 64'(0));
        chk("rst_data1_q", oq1, 64'(0));
        chk("rst_overflow", 64'({ovf1, ovf0}), 64'(0));
        for (int g = 0; g < 6; g++) begin
            sbq[g].delete();
            left[g] = 0;
        end
        for (int d = 0; d < 2; d++) begin
            k[d] = 0;
            drain_flag[d] = 1'b0;
            done_seen[d] = 1'b0;
            ovf_exp[d] = 1'b0;
        end
        exp_next = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    // vmode: 0 back-to-back, 1 alternating 1-0, 2 random gaps.
    // rmode: 0 all ready, 1 random, 2 ch0 toggling / ch1 held low for 20 cycles.
    task automatic run_frame(input int d, input int vmode, input int rmode, input bit seq,
                             input bit inj);
        int sent;
        int cyc;
        int pending;
        logic v;
        logic [5:0] r;
        sent = 0;
        cyc = 0;
        while (sent < nfft_of(d)) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            step(d == 0 && v, d == 1 && v, 6'($urandom), seq);
            if (v) sent++;
            cyc++;
        end
        cyc = 0;
        while (drain_flag[d] && cyc < 200) begin
            case (rmode)
                0:       r = '1;
                1:       r = 6'($urandom);
                default: r = {4'($urandom), (cyc >= 20), (cyc % 2 == 0)};
            endcase
            v = inj && (cyc < 3);
            step(d == 0 && v, d == 1 && v, r, seq);
            cyc++;
        end
        chk($sformatf("drain_finished_dut%0d", d), 64'(drain_flag[d]), 64'(0));
        pending = 0;
        for (int c = 0; c < nch_of(d); c++) pending += sbq[base_of(d) + c].size();
        chk($sformatf("words_left_dut%0d", d), 64'(pending), 64'(0));
        if (drain_flag[d]) do_reset();
    endtask

    task automatic check_ch(input int g, input logic c, input logic l, input logic [W-1:0] i,
                            input logic [W-1:0] q);
        logic [2*W:0] e;
        if (c || exp_cmp[g]) begin
            chk($sformatf("complete_ch%0d", g), 64'(c), 64'(exp_cmp[g]));
        end
        if (c === 1'b1) begin
            chk($sformatf("word_expected_ch%0d", g), 64'(sbq[g].size() != 0), 64'(1));
            if (sbq[g].size() != 0) begin
                e = sbq[g].pop_front();
                chk($sformatf("word_ch%0d", g), 64'({i, q, l}), 64'(e));
            end
        end
    endtask

    always @(posedge clk) exp_cmp <= exp_next;

    // Monitor: outputs sampled on the falling edge, compared against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < 2; c++) begin
                check_ch(c, cmp0[c], last0[c], oi0[c*W +: W], oq0[c*W +: W]);
            end
            for (int c = 0; c < 4; c++) begin
                check_ch(c + 2, cmp1[c], last1[c], oi1[c*W +: W], oq1[c*W +: W]);
            end
            chk("ready_to_fft0", 64'(rs0), 64'(!drain_flag[0]));
            chk("ready_to_fft1", 64'(rs1), 64'(!drain_flag[1]));
            chk("state0", 64'(st0), 64'(exp_st(0)));
            chk("state1", 64'(st1), 64'(exp_st(1)));
            chk("overflow0", 64'(ovf0), 64'(ovf_exp[0]));
            chk("overflow1", 64'(ovf1), 64'(ovf_exp[1]));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        fv0 = 1'b0;
        fv1 = 1'b0;
        di0 = '0;
        dq0 = '0;
        di1 = '0;
        dq1 = '0;
        ready_g = '0;
        @(posedge clk);
        #1;
        do_reset();
        run_frame(0, 0, 0, 1'b1, 1'b0);   // I = 0..7 back-to-back, both ready
        run_frame(0, 1, 0, 1'b1, 1'b0);   // same words with 1-0 input gaps
        run_frame(0, 0, 2, 1'b0, 1'b0);   // backpressure
        run_frame(0, 0, 0, 1'b1, 1'b1);   // samples pushed during drain
        run_frame(0, 2, 1, 1'b0, 1'b0);   // overflow must still read 1
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'($urandom), 1'b0);
        do_reset();                        // reset at k = 3 of a frame
        run_frame(0, 0, 0, 1'b1, 1'b0);
        run_frame(1, 0, 0, 1'b1, 1'b0);   // block mode, ch2 gets 8..11
        for (int n = 0; n < 6; n++) run_frame(n % 2, 2, 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'($urandom), 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
